// File: rtl/sfx_pkg.sv
// Shared definitions for the buzzer sound-effect arbiter: source indices,
// note-period table and FSM state encoding.
package sfx_pkg;

   localparam int SFX_UP    = 0;
   localparam int SFX_DOWN  = 1;
   localparam int SFX_HIT   = 2;
   localparam int SFX_OVER  = 3;

   localparam int SFX_NUM   = 4;
   localparam int SFX_NOTES = 4;
   localparam int SFX_PW    = 20;

   typedef logic [SFX_PW-1:0] sfx_period_t;

   // Row = source, column = note; a zero entry is a rest.
   localparam sfx_period_t SFX_TABLE [SFX_NUM][SFX_NOTES] = '{
      '{20'd190835, 20'd151745, 20'd127551, 20'd95420 },
      '{20'd255102, 20'd303030, 20'd381679, 20'd454545},
      '{20'd113636, 20'd0,      20'd113636, 20'd0     },
      '{20'd255102, 20'd303030, 20'd381679, 20'd0     }
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2
   } sfx_state_t;

   function automatic logic [1:0] sfx_top_bit(input logic [3:0] v);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) r = 2'(i);
      end
      return r;
   endfunction

   // Bits strictly above cur; empty for cur = 3 because the shift drops out.
   function automatic logic [3:0] sfx_above_mask(input logic [1:0] cur);
      return ~((4'b0010 << cur) - 4'd1);
   endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave tone generator: beep is high for the first period/2 cycles of
// every period, restarting whenever the period value changes.
module sfx_tone_gen
   import sfx_pkg::*;
#(
   parameter int PW = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [PW-1:0] i_period,
   output logic          o_beep
);

   logic [PW-1:0] r_tcnt;
   logic [PW-1:0] r_prev;
   logic          r_beep;
   logic [PW-1:0] w_cnt;
   logic          w_restart;

   assign w_restart = (i_period == '0) || (i_period != r_prev);

   always_comb begin
      w_cnt = r_tcnt;
      if (w_restart) w_cnt = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt <= '0;
         r_prev <= '0;
         r_beep <= 1'b0;
      end else begin
         r_prev <= i_period;
         r_beep <= (i_period != '0) && (w_cnt < (i_period >> 1));
         if ((i_period == '0) || (w_cnt == i_period - PW'(1)))
            r_tcnt <= '0;
         else
            r_tcnt <= w_cnt + PW'(1);
      end
   end

   // Gating with the live period silences the pin on the same edge a
   // flush or preemption zeroes the period, instead of one cycle later.
   assign o_beep = r_beep & (i_period != '0);

endmodule

// File: rtl/sfx_arbiter.sv
// Sound-effect arbiter: latches request edges, grants by fixed priority with
// preemption, and steps the granted effect through its four notes.
//   state | meaning
//   IDLE  | no effect playing; grants the highest pending source
//   LOAD  | one-cycle gap loading the next note period
//   PLAY  | note timer running down to terminal count
module sfx_arbiter
   import sfx_pkg::*;
#(
   parameter int NOTE_CYCLES = 2_500_000,
   parameter int PW          = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_enable,
   input  logic [3:0]    i_req,
   output logic [3:0]    o_grant,
   output logic          o_busy,
   output logic [PW-1:0] o_period,
   output logic          o_beep
);

   localparam int CW = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;

   sfx_state_t    r_state;
   logic [3:0]    r_req_q;
   logic [3:0]    r_pending;
   logic [3:0]    r_grant;
   logic [1:0]    r_cur;
   logic [1:0]    r_idx;
   logic [CW-1:0] r_note_cnt;
   logic [PW-1:0] r_period;
   logic          r_busy;

   logic [3:0]    w_rise;
   logic [1:0]    w_top;
   logic          w_preempt;

   assign w_rise    = i_req & ~r_req_q;
   assign w_top     = sfx_top_bit(r_pending);
   assign w_preempt = |(r_pending & sfx_above_mask(r_cur));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_req_q <= '0;
      else     r_req_q <= i_req;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_pending  <= '0;
         r_grant    <= '0;
         r_cur      <= '0;
         r_idx      <= '0;
         r_note_cnt <= '0;
         r_period   <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_grant <= '0;
         if (!i_enable) begin
            r_pending <= '0;
            r_state   <= ST_IDLE;
            r_period  <= '0;
            r_busy    <= 1'b0;
         end else begin
            r_pending <= r_pending | w_rise;
            case (r_state)
               ST_IDLE: begin
                  if (r_pending != '0) begin
                     r_grant   <= 4'b0001 << w_top;
                     r_pending <= (r_pending & ~(4'b0001 << w_top)) | w_rise;
                     r_cur     <= w_top;
                     r_idx     <= '0;
                     r_state   <= ST_LOAD;
                     r_busy    <= 1'b1;
                  end
               end
               ST_LOAD, ST_PLAY: begin
                  // The preempted source is dropped; its pending bit was already consumed.
                  if (w_preempt) begin
                     r_state  <= ST_IDLE;
                     r_period <= '0;
                     r_busy   <= 1'b0;
                  end else if (r_state == ST_LOAD) begin
                     r_period   <= PW'(SFX_TABLE[r_cur][r_idx]);
                     r_note_cnt <= CW'(NOTE_CYCLES - 1);
                     r_state    <= ST_PLAY;
                  end else if (r_note_cnt == '0) begin
                     if (r_idx == 2'd3) begin
                        r_state  <= ST_IDLE;
                        r_period <= '0;
                        r_busy   <= 1'b0;
                     end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= ST_LOAD;
                     end
                  end else begin
                     r_note_cnt <= r_note_cnt - CW'(1);
                  end
               end
               default: begin
                  r_state  <= ST_IDLE;
                  r_period <= '0;
                  r_busy   <= 1'b0;
               end
            endcase
         end
      end
   end

   sfx_tone_gen #(.PW(PW)) u_tone (
      .clk      (clk),
      .rst      (rst),
      .i_period (r_period),
      .o_beep   (o_beep)
   );

   assign o_grant  = r_grant;
   assign o_busy   = r_busy;
   assign o_period = r_period;

endmodule
